// File: rtl/lcd_tile_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_tile_sequencer
//   Command/data byte sequencer for an ILI9341-style 8-bit LCD bus. It runs
//   either the power-on init sequence or a tile fill, which is made of:
//     - a column window (2A),
//     - a page window (2B),
//     - RAMWR (2C),
//     - TILE_W*TILE_H RGB565 pixels, high byte first.
//   Every byte is handed to the bus writer through a valid/ready handshake.
//
// Optional feature: define TILE_BORDER_EN to draw the outer ring of every
// tile in BORDER_COL; interior pixels keep the object's table colour.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   init_req, draw_req   sequence requests, sampled only in IDLE (init wins)
//   X, Y, obj_code       tile position and object code, latched on draw accept
//   busy, done           busy from accept until completion, 1-cycle done pulse
//   out_valid, out_ready byte handshake towards the bus writer
//   D, dcx               byte and its type (0 = command, 1 = data)
// ---------------------------------------------------------------------------
module lcd_tile_sequencer #(
    parameter int          TILE_W     = 20,
    parameter int          TILE_H     = 20,
    parameter int          COORD_W    = 4,
    parameter int          OBJ_W      = 3,
    parameter int          INIT_DELAY = 50000,
    parameter logic [15:0] BORDER_COL = 16'h0000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               init_req,
    input  logic               draw_req,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic [OBJ_W-1:0]   obj_code,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         D,
    output logic               dcx
);

`ifdef TILE_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    localparam int              CNT_W    = $clog2(INIT_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_DELAY - 1);
    localparam logic [7:0]      COL_LAST = 8'(TILE_W - 1);
    localparam logic [7:0]      ROW_LAST = 8'(TILE_H - 1);
    localparam logic [15:0]     TW16     = 16'(TILE_W);
    localparam logic [15:0]     TH16     = 16'(TILE_H);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_HDR, S_PIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               valid_q, valid_d, dcx_q, dcx_d;
    logic [7:0]         d_q, d_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         col_q, col_d, row_q, row_d;
    logic               half_q, half_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [OBJ_W-1:0]   obj_q, obj_d;

    logic               accept, last_col;
    logic [7:0]         nxt_col, nxt_row;
    logic [15:0]        sc, ec, sp, ep;
    logic [15:0]        cur_colour, nxt_colour, first_colour;
    logic [7:0]         hdr_next;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h01;
            2'd1:    return 8'h11;
            2'd2:    return 8'h28;
            default: return 8'h29;
        endcase
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [3:0] i, input logic [15:0] c0,
                                            input logic [15:0] c1, input logic [15:0] p0,
                                            input logic [15:0] p1);
        case (i)
            4'd0:    return 8'h2A;
            4'd1:    return c0[15:8];
            4'd2:    return c0[7:0];
            4'd3:    return c1[15:8];
            4'd4:    return c1[7:0];
            4'd5:    return 8'h2B;
            4'd6:    return p0[15:8];
            4'd7:    return p0[7:0];
            4'd8:    return p1[15:8];
            4'd9:    return p1[7:0];
            default: return 8'h2C;
        endcase
    endfunction

    function automatic logic [15:0] pixel_colour(input logic [OBJ_W-1:0] obj,
                                                 input logic [7:0] row, input logic [7:0] col);
        logic [15:0] c;
        case (32'(obj))
            1:       c = 16'h901E;
            2:       c = 16'h6815;
            3:       c = 16'hF800;
            4:       c = 16'h0814;
            default: c = 16'hFFFF;
        endcase
        if (BORDER_EN && (row == 8'd0 || row == ROW_LAST || col == 8'd0 || col == COL_LAST))
            c = BORDER_COL;
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        d_d     = d_q;
        dcx_d   = dcx_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        half_d  = half_q;
        x_d     = x_q;
        y_d     = y_q;
        obj_d   = obj_q;

        // out_ready only matters while a byte is actually offered
        accept   = valid_q && out_ready;

        sc = 16'(32'(x_q) * 32'(TILE_W));
        ec = sc + TW16 - 16'd1;
        sp = 16'(32'(y_q) * 32'(TILE_H));
        ep = sp + TH16 - 16'd1;
        hdr_next = hdr_byte(idx_q + 4'd1, sc, ec, sp, ep);

        // raster walk: column wraps to 0 and bumps the row
        last_col     = (col_q == COL_LAST);
        nxt_col      = last_col ? 8'd0 : col_q + 8'd1;
        nxt_row      = last_col ? row_q + 8'd1 : row_q;
        cur_colour   = pixel_colour(obj_q, row_q, col_q);
        nxt_colour   = pixel_colour(obj_q, nxt_row, nxt_col);
        first_colour = pixel_colour(obj_q, 8'd0, 8'd0);

        case (state_q)
            S_IDLE: begin
                if (init_req) begin
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    d_d     = 8'h01;
                    dcx_d   = 1'b0;
                    idx_d   = 4'd0;
                end else if (draw_req) begin
                    state_d = S_HDR;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    d_d     = 8'h2A;
                    dcx_d   = 1'b0;
                    idx_d   = 4'd0;
                    col_d   = 8'd0;
                    row_d   = 8'd0;
                    half_d  = 1'b0;
                    x_d     = X;
                    y_d     = Y;
                    obj_d   = obj_code;
                end
            end
            S_INIT: begin
                if (accept) begin
                    case (idx_q[1:0])
                        2'd0, 2'd1: begin
                            state_d = S_WAIT;
                            valid_d = 1'b0;
                            cnt_d   = '0;
                        end
                        2'd2: begin
                            idx_d = 4'd3;
                            d_d   = 8'h29;
                        end
                        default: begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                // cnt_q runs 0..INIT_DELAY-1 with out_valid low throughout
                if (cnt_q == CNT_LAST) begin
                    state_d = S_INIT;
                    idx_d   = idx_q + 4'd1;
                    valid_d = 1'b1;
                    d_d     = init_byte(idx_q[1:0] + 2'd1);
                    dcx_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (idx_q == 4'd10) begin
                        state_d = S_PIX;
                        d_d     = first_colour[15:8];
                        dcx_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        d_d   = hdr_next;
                        // 2A, 2B and 2C (indices 0, 5, 10) are commands
                        dcx_d = (idx_q + 4'd1 != 4'd5) && (idx_q + 4'd1 != 4'd10);
                    end
                end
            end
            S_PIX: begin
                if (accept) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                        d_d    = cur_colour[7:0];
                    end else if (last_col && row_q == ROW_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        col_d  = nxt_col;
                        row_d  = nxt_row;
                        d_d    = nxt_colour[15:8];
                    end
                end
            end
            S_DONE: begin
                // requests are not sampled here, only from the next cycle on
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            d_q     <= 8'h00;
            dcx_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            half_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            obj_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            d_q     <= d_d;
            dcx_q   <= dcx_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            half_q  <= half_d;
            x_q     <= x_d;
            y_q     <= y_d;
            obj_q   <= obj_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign D         = d_q;
    assign dcx       = dcx_q;

endmodule

// File: tb/tb_lcd_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_tile_sequencer
//   Directed/randomised bench for lcd_tile_sequencer (20x20 tiles, short init
//   delay). Expected byte streams come from a behavioural model of the
//   command protocol built from tile coordinates and the colour table.
// ---------------------------------------------------------------------------
module tb_lcd_tile_sequencer;

    localparam int TW = 20;
    localparam int TH = 20;
    localparam int CW = 4;
    localparam int OW = 3;
    localparam int ID = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          init_req, draw_req, out_ready;
    logic [CW-1:0] X, Y;
    logic [OW-1:0] obj_code;
    logic          busy, done, out_valid, dcx;
    logic [7:0]    D;

    lcd_tile_sequencer #(
        .TILE_W(TW), .TILE_H(TH), .COORD_W(CW), .OBJ_W(OW),
        .INIT_DELAY(ID), .BORDER_COL(16'h0000)
    ) dut (
        .clk(clk), .nrst(nrst), .init_req(init_req), .draw_req(draw_req),
        .X(X), .Y(Y), .obj_code(obj_code), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .D(D), .dcx(dcx)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] got_q[$];
    int         got_t[$];
    logic [8:0] exp_q[$];
    bit         done_seen;
    int         done_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [15:0] colour_of(input int obj, input int r, input int c);
        logic [15:0] col;
        case (obj)
            0: col = 16'hFFFF;
            1: col = 16'h901E;
            2: col = 16'h6815;
            3: col = 16'hF800;
            4: col = 16'h0814;
            default: col = 16'hFFFF;
        endcase
`ifdef TILE_BORDER_EN
        if (r == 0 || r == TH - 1 || c == 0 || c == TW - 1) col = 16'h0000;
`endif
        return col;
    endfunction

    task automatic push_word(input bit is_data, input int w);
        logic [15:0] v;
        v = w[15:0];
        exp_q.push_back({is_data, v[15:8]});
        exp_q.push_back({is_data, v[7:0]});
    endtask

    task automatic build_fill(input int x, input int y, input int obj);
        int sc, sp;
        logic [15:0] col;
        sc = (x * TW) & 16'hFFFF;
        sp = (y * TH) & 16'hFFFF;
        exp_q.delete();
        exp_q.push_back(9'h02A);
        push_word(1'b1, sc);
        push_word(1'b1, sc + TW - 1);
        exp_q.push_back(9'h02B);
        push_word(1'b1, sp);
        push_word(1'b1, sp + TH - 1);
        exp_q.push_back(9'h02C);
        for (int p = 0; p < TW * TH; p++) begin
            col = colour_of(obj, p / TW, p % TW);
            push_word(1'b1, int'(col));
        end
    endtask

    task automatic build_init();
        exp_q.delete();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h028);
        exp_q.push_back(9'h029);
    endtask

    task automatic compare_stream(input string tag);
        int bad = -1;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0)
            $display("  %s first differing byte %0d got %h exp %h", tag, bad, got_q[bad], exp_q[bad]);
        chk({tag, "_first_bad_idx"}, bad, -1);
    endtask

    // Observe at negedges: record bytes accepted at the following posedge.
    task automatic collect(input bit rnd_ready, input bit noise_draw,
                           input int stop_after, input int budget);
        bit         held = 1'b0;
        logic [8:0] hv   = '0;
        int         cyc  = 0;
        got_q.delete();
        got_t.delete();
        done_seen = 1'b0;
        done_t    = -1;
        while (cyc < budget && !done_seen && !(stop_after > 0 && got_q.size() >= stop_after)) begin
            if (held) chk("stall_hold", 32'({out_valid, dcx, D}), 32'({1'b1, hv}));
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_t    = cyc;
                chk("busy_in_done_cycle", 32'(busy), 32'd0);
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (noise_draw) draw_req = 1'($urandom_range(0, 1));
                if (out_valid === 1'b1 && out_ready) begin
                    got_q.push_back({dcx, D});
                    got_t.push_back(cyc);
                end
                held = (out_valid === 1'b1) && !out_ready;
                hv   = {dcx, D};
                @(negedge clk);
                cyc++;
            end
        end
        draw_req = 1'b0;
        if (stop_after == 0) chk("done_within_budget", 32'(done_seen), 32'd1);
    endtask

    task automatic start(input bit ireq, input bit dreq, input int x, input int y, input int obj);
        @(negedge clk);
        init_req = ireq;
        draw_req = dreq;
        X        = CW'(x);
        Y        = CW'(y);
        obj_code = OW'(obj);
        @(negedge clk);
        init_req = 1'b0;
        draw_req = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    initial begin
        int x, y, o, quiet;
        nrst = 1'b0; init_req = 1'b0; draw_req = 1'b0; out_ready = 1'b0;
        X = '0; Y = '0; obj_code = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_d_dcx", 32'({dcx, D}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // init sequence, writer always ready
        start(1'b1, 1'b0, 0, 0, 0);
        collect(1'b0, 1'b0, 0, 200);
        build_init();
        compare_stream("init");
        chk("init_t_11", got_t.size() > 1 ? got_t[1] : -1, 1 + ID);
        chk("init_t_28", got_t.size() > 2 ? got_t[2] : -1, 2 + 2 * ID);
        chk("init_t_29", got_t.size() > 3 ? got_t[3] : -1, 3 + 2 * ID);
        chk("init_t_done", done_t, 4 + 2 * ID);

        // request raised in the done cycle is accepted one cycle later
        draw_req = 1'b1; X = 4'd2; Y = 4'd3; obj_code = 3'd3;
        @(negedge clk);
        chk("no_accept_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        draw_req = 1'b0;
        chk("accept_after_done", 32'(busy), 32'd1);
        chk("first_fill_byte", 32'({out_valid, dcx, D}), 32'h22A);
        collect(1'b0, 1'b0, 0, 2000);
        build_fill(2, 3, 3);
        compare_stream("fill_2_3_3");
        chk("fill_last_byte_t", got_t.size() > 0 ? got_t[got_t.size() - 1] : -1, 810);
        chk("fill_done_t", done_t, 811);

        // same tile with random stalls
        start(1'b0, 1'b1, 2, 3, 3);
        collect(1'b1, 1'b0, 0, 8000);
        compare_stream("fill_stall");

        // init and draw together: init wins; draws while busy ignored
        start(1'b1, 1'b1, 5, 5, 1);
        collect(1'b1, 1'b1, 0, 400);
        build_init();
        compare_stream("init_prio");

        // random tiles with stalls and busy-time draw requests
        for (int k = 0; k < 3; k++) begin
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            o = $urandom_range(0, 7);
            start(1'b0, 1'b1, x, y, o);
            collect(1'(k & 1), 1'b1, 0, 8000);
            build_fill(x, y, o);
            compare_stream($sformatf("fill_rand%0d", k));
        end

        // obj 7 -> white, then reset in the middle of the pixels
        start(1'b0, 1'b1, 1, 1, 7);
        collect(1'b1, 1'b0, 100, 4000);
        build_fill(1, 1, 7);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        compare_stream("fill_obj7_prefix");
        nrst = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        out_ready = 1'b1;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet++;
        end
        chk("silent_after_abort", quiet, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
